cache_controller: RTL and testbench

// - Drives the direct-mapped cache array from the CPU side and moves whole blocks to and from main memory.
// - Sits between the CPU load/store port, the cache array (addr/data_write/dirty_write/write_en in, hit/data_read/dirty_read out) and the block-wide memory port.
// - Write-back, write-allocate; one outstanding CPU request.

---
 rtl/cache_controller_if.sv | 56 +++++
 rtl/cache_controller.sv | 190 +++++++++++++++++++
 tb/tb_cache_controller.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_if.sv
// Interface: cache_controller_if
// Bundles the CPU load/store port, the cache array port and the block-wide memory port.
interface cache_controller_if #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 256,
  parameter int unsigned CACHE_SIZE = 65536
);
  localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE / DATA_WIDTH);
  localparam int unsigned INDEX_WIDTH  = $clog2(CACHE_SIZE * 8 / BLOCK_SIZE);
  localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

  // CPU side
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;

  // Cache array side
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [BLOCK_SIZE-1:0] cm_data_write;
  logic                  cm_dirty_write;
  logic                  cm_write_en;
  logic [BLOCK_SIZE-1:0] cm_data_read;
  logic                  cm_dirty_read;
  logic [TAG_WIDTH-1:0]  cm_tag_read;
  logic                  cm_hit;

  // Main memory side
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic [BLOCK_SIZE-1:0] mem_rdata;
  logic                  mem_valid;

  modport master (
    input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    output cpu_rdata, cpu_ready,
    output cm_addr, cm_data_write, cm_dirty_write, cm_write_en,
    input  cm_data_read, cm_dirty_read, cm_tag_read, cm_hit,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_valid
  );

  modport slave (
    output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
    input  cpu_rdata, cpu_ready,
    input  cm_addr, cm_data_write, cm_dirty_write, cm_write_en,
    output cm_data_read, cm_dirty_read, cm_tag_read, cm_hit,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_valid
  );
endinterface

// File: rtl/cache_controller.sv
// Write-back, write-allocate controller for a direct-mapped cache with one outstanding request.
// Optional hit/miss counters are enabled by defining CC_STATS_EN.
module cache_controller #(
  parameter int unsigned ADDR_WIDTH = 28,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 256,
  parameter int unsigned CACHE_SIZE = 65536
) (
  input  logic               clk,
  input  logic               rst_n,
  cache_controller_if.master bus
`ifdef CC_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE / DATA_WIDTH);
  localparam int unsigned INDEX_WIDTH  = $clog2(CACHE_SIZE * 8 / BLOCK_SIZE);
  localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned WORD_LSB_W   = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate,
    StFill
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    is_store_q;
  logic [ADDR_WIDTH-1:0]   wb_addr_q;
  logic [BLOCK_SIZE-1:0]   wb_data_q;
  logic [BLOCK_SIZE-1:0]   fill_q;

  logic [OFFSET_WIDTH-1:0] offset;
  logic [INDEX_WIDTH-1:0]  index;
  logic [TAG_WIDTH-1:0]    tag;
  logic [OFFSET_WIDTH+WORD_LSB_W-1:0] word_lsb;
  logic [BLOCK_SIZE-1:0]   merged;

  logic accept;
  logic wb_start;
  logic fill_take;

  assign offset   = addr_q[OFFSET_WIDTH-1:0];
  assign index    = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign tag      = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign word_lsb = {offset, {WORD_LSB_W{1'b0}}};

  assign accept    = (state_q == StIdle) && (bus.cpu_rd || bus.cpu_wr);
  assign wb_start  = (state_q == StCompare) && !bus.cm_hit && bus.cm_dirty_read;
  assign fill_take = (state_q == StAllocate) && bus.mem_valid;

  // The array is indexed by the latched request, so it stays put for the whole transaction.
  assign bus.cm_addr = addr_q;

  always_comb begin
    merged = bus.cm_data_read;
    merged[word_lsb +: DATA_WIDTH] = wdata_q;
  end

  always_comb begin
    state_d            = state_q;
    bus.cpu_rdata      = '0;
    bus.cpu_ready      = 1'b0;
    bus.cm_data_write  = '0;
    bus.cm_dirty_write = 1'b0;
    bus.cm_write_en    = 1'b0;
    bus.mem_addr       = '0;
    bus.mem_rd         = 1'b0;
    bus.mem_wr         = 1'b0;
    bus.mem_wdata      = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCompare;
        end
      end

      StCompare: begin
        if (bus.cm_hit) begin
          bus.cpu_ready = 1'b1;
          state_d       = StIdle;
          if (is_store_q) begin
            bus.cm_write_en    = 1'b1;
            bus.cm_dirty_write = 1'b1;
            bus.cm_data_write  = merged;
          end else begin
            bus.cpu_rdata = bus.cm_data_read[word_lsb +: DATA_WIDTH];
          end
        end else if (bus.cm_dirty_read) begin
          state_d = StWriteback;
        end else begin
          state_d = StAllocate;
        end
      end

      StWriteback: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = wb_addr_q;
        bus.mem_wdata = wb_data_q;
        if (bus.mem_valid) begin
          state_d = StAllocate;
        end
      end

      StAllocate: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = {tag, index, {OFFSET_WIDTH{1'b0}}};
        if (bus.mem_valid) begin
          state_d = StFill;
        end
      end

      StFill: begin
        bus.cm_write_en    = 1'b1;
        bus.cm_dirty_write = 1'b0;
        bus.cm_data_write  = fill_q;
        state_d            = StCompare;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_store_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      fill_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= bus.cpu_addr;
        wdata_q    <= bus.cpu_wdata;
        is_store_q <= bus.cpu_wr;
      end
      // Victim address and data are frozen here so the writeback stays stable under a slow memory.
      if (wb_start) begin
        wb_addr_q <= {bus.cm_tag_read, index, {OFFSET_WIDTH{1'b0}}};
        wb_data_q <= bus.cm_data_read;
      end
      if (fill_take) begin
        fill_q <= bus.mem_rdata;
      end
    end
  end

`ifdef CC_STATS_EN
  logic        first_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Only the first COMPARE of a request counts; the post-fill COMPARE always hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (accept) begin
        first_q <= 1'b1;
      end else if (state_q == StCompare) begin
        first_q <= 1'b0;
      end
      if ((state_q == StCompare) && first_q) begin
        if (bus.cm_hit) begin
          hit_cnt_q <= hit_cnt_q + 32'd1;
        end else begin
          miss_cnt_q <= miss_cnt_q + 32'd1;
        end
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed scenarios then random traffic, checked against a
// word-level golden memory plus a per-index residency model.
module tb_cache_controller;

  logic clk;
  logic rst_n;

  cache_controller_if #(
    .ADDR_WIDTH(28), .DATA_WIDTH(32), .BLOCK_SIZE(256), .CACHE_SIZE(65536)
  ) bus ();

`ifdef CC_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  cache_controller dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef CC_STATS_EN
    ,
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache array: combinational read at cm_addr, commit on the falling edge.
  logic [255:0] arr_data  [2048] = '{default: '0};
  logic [13:0]  arr_tag   [2048] = '{default: '0};
  logic         arr_valid [2048] = '{default: 1'b0};
  logic         arr_dirty [2048] = '{default: 1'b0};
  logic [10:0]  cm_idx;

  assign cm_idx            = bus.cm_addr[13:3];
  assign bus.cm_data_read  = arr_data[cm_idx];
  assign bus.cm_tag_read   = arr_tag[cm_idx];
  assign bus.cm_dirty_read = arr_valid[cm_idx] && arr_dirty[cm_idx];
  assign bus.cm_hit        = arr_valid[cm_idx] && (arr_tag[cm_idx] == bus.cm_addr[27:14]);

  always @(negedge clk) begin
    if (bus.cm_write_en) begin
      arr_data[cm_idx]  <= bus.cm_data_write;
      arr_tag[cm_idx]   <= bus.cm_addr[27:14];
      arr_valid[cm_idx] <= 1'b1;
      arr_dirty[cm_idx] <= bus.cm_dirty_write;
    end
  end

  // Main memory contents and the golden architectural view.
  logic [255:0] mem_blk [logic [27:0]];
  logic [31:0]  gold    [logic [27:0]];
  bit           r_valid [2048];
  bit [13:0]    r_tag   [2048];
  bit           r_dirty [2048];

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  function automatic logic [31:0] init_word(input logic [27:0] a);
    return (32'({4'b0, a}) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] gold_rd(input logic [27:0] a);
    if (gold.exists(a)) return gold[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] gold_blk(input logic [27:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = gold_rd(b + 28'(i));
    return r;
  endfunction

  function automatic logic [255:0] mem_read(input logic [27:0] b);
    logic [255:0] r;
    if (mem_blk.exists(b)) return mem_blk[b];
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = init_word(b + 28'(i));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One CPU request with a memory that acknowledges after the given wait cycles.
  task automatic do_req(input bit st, input logic [27:0] a, input logic [31:0] wd,
                        input int unsigned wb_dly, input int unsigned rd_dly);
    logic [10:0]  idx;
    logic [13:0]  tg;
    logic [27:0]  blk, wb_a, wr_a0, rd_a0;
    logic [255:0] pre_blk, wb_blk, merged, wr_d0;
    logic [31:0]  exp_rdata, rdata;
    bit           hit, wb, done;
    int unsigned  off, exp_k, k, ready_k, wr_cyc, rd_cyc, we_cyc, bad;

    idx       = a[13:3];
    tg        = a[27:14];
    off       = 32'(a[2:0]);
    blk       = {a[27:3], 3'b000};
    hit       = r_valid[idx] && (r_tag[idx] == tg);
    wb        = !hit && r_valid[idx] && r_dirty[idx];
    wb_a      = {r_tag[idx], idx, 3'b000};
    wb_blk    = gold_blk(wb_a);
    pre_blk   = gold_blk(blk);
    merged    = pre_blk;
    merged[off*32 +: 32] = wd;
    exp_rdata = gold_rd(a);
    exp_k     = hit ? 1 : 3 + (wb ? wb_dly + 1 : 0) + rd_dly + 1;
    if (hit) exp_hits++; else exp_misses++;

    bus.cpu_addr  = a;
    bus.cpu_wdata = wd;
    bus.cpu_wr    = st;
    bus.cpu_rd    = st ? ($urandom_range(3, 0) == 0) : 1'b1;
    @(posedge clk); #1;

    k = 0; ready_k = 0; done = 0; wr_cyc = 0; rd_cyc = 0; we_cyc = 0; bad = 0;
    rdata = '0; wr_a0 = '0; rd_a0 = '0; wr_d0 = '0;
    while (!done && k < 200) begin
      k++;
      bus.mem_valid = 1'b0;
      if (bus.mem_rd && bus.mem_wr) bad++;
      if (bus.mem_wr) begin
        if (wr_cyc == 0) begin
          wr_a0 = bus.mem_addr;
          wr_d0 = bus.mem_wdata;
        end else if (bus.mem_addr !== wr_a0 || bus.mem_wdata !== wr_d0) begin
          bad++;
        end
        wr_cyc++;
        if (wr_cyc == wb_dly + 1) begin
          bus.mem_valid = 1'b1;
          mem_blk[bus.mem_addr] = bus.mem_wdata;
        end
      end
      if (bus.mem_rd) begin
        if (rd_cyc == 0) rd_a0 = bus.mem_addr;
        else if (bus.mem_addr !== rd_a0) bad++;
        rd_cyc++;
        if (rd_cyc == rd_dly + 1) begin
          bus.mem_valid = 1'b1;
          bus.mem_rdata = mem_read(bus.mem_addr);
        end
      end
      if (!bus.mem_rd && !bus.mem_wr) begin
        // Stray acknowledges must be ignored outside the memory states.
        bus.mem_valid = 1'($urandom_range(1, 0));
        bus.mem_rdata = {8{$urandom()}};
      end
      if (bus.cm_write_en) begin
        we_cyc++;
        if (bus.cpu_ready) begin
          chk("store_dirty", 256'(bus.cm_dirty_write), 256'(1));
          chk("store_data", bus.cm_data_write, merged);
        end else begin
          chk("fill_dirty", 256'(bus.cm_dirty_write), 256'(0));
          chk("fill_data", bus.cm_data_write, pre_blk);
        end
      end
      if (bus.cpu_ready) begin
        done    = 1;
        ready_k = k;
        rdata   = bus.cpu_rdata;
      end
      if (!done) begin
        bus.cpu_rd    = 1'($urandom_range(1, 0));
        bus.cpu_wr    = 1'($urandom_range(1, 0));
        bus.cpu_addr  = 28'($urandom());
        bus.cpu_wdata = $urandom();
        @(posedge clk); #1;
      end else begin
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.mem_valid = 1'b0;
      end
    end

    chk("completed", 256'(done), 256'(1));
    chk("ready_latency", 256'(ready_k), 256'(exp_k));
    if (!st) chk("load_data", 256'(rdata), 256'(exp_rdata));
    chk("wb_cycles", 256'(wr_cyc), 256'(wb ? wb_dly + 1 : 0));
    if (wb) begin
      chk("wb_addr", 256'(wr_a0), 256'(wb_a));
      chk("wb_data", wr_d0, wb_blk);
    end
    chk("rd_cycles", 256'(rd_cyc), 256'(hit ? 0 : rd_dly + 1));
    if (!hit) chk("rd_addr", 256'(rd_a0), 256'(blk));
    chk("array_writes", 256'(we_cyc), 256'((hit ? 0 : 1) + (st ? 1 : 0)));
    chk("mem_rules", 256'(bad), 256'(0));

    @(posedge clk); #1;
    chk("idle_quiet", 256'({bus.cpu_ready, bus.mem_rd, bus.mem_wr, bus.cm_write_en}), 256'(0));

    if (st) gold[a] = wd;
    r_dirty[idx] = (hit ? r_dirty[idx] : 1'b0) | st;
    r_valid[idx] = 1'b1;
    r_tag[idx]   = tg;
  endtask

  initial begin
    int unsigned k;
    int unsigned leak;
    logic [27:0] a;

    rst_n         = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_valid = 1'b0;
    #1;
    chk("reset_cpu", 256'({bus.cpu_ready, bus.cpu_rdata}), 256'(0));
    chk("reset_cm", 256'({bus.cm_write_en, bus.cm_dirty_write, bus.cm_addr}), 256'(0));
    chk("reset_cm_data", bus.cm_data_write, 256'(0));
    chk("reset_mem", 256'({bus.mem_rd, bus.mem_wr, bus.mem_addr}), 256'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 28'h000_0010, 32'h0, 0, 0);
    chk("first_load_word0", 256'(gold_rd(28'h000_0010)), 256'(init_word(28'h000_0010)));
    do_req(1'b0, 28'h000_0013, 32'h0, 0, 0);
    do_req(1'b1, 28'h000_0013, 32'hDEAD_BEEF, 0, 0);
    do_req(1'b0, 28'h000_4010, 32'h0, 5, 5);
    do_req(1'b0, 28'h000_0013, 32'h0, 0, 2);
    chk("stored_word_back", 256'(gold_rd(28'h000_0013)), 256'(32'hDEAD_BEEF));

    // Reset while a refill is outstanding: everything drops at once, no completion.
    bus.cpu_addr = 28'h000_8010;
    bus.cpu_rd   = 1'b1;
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0;
    k = 0;
    while (!bus.mem_rd && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reached_allocate", 256'(bus.mem_rd), 256'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem", 256'({bus.mem_rd, bus.mem_wr, bus.mem_addr}), 256'(0));
    chk("arst_cpu", 256'({bus.cpu_ready, bus.cpu_rdata}), 256'(0));
    chk("arst_cm", 256'({bus.cm_write_en, bus.cm_dirty_write, bus.cm_addr}), 256'(0));
    chk("arst_wdata", bus.mem_wdata, 256'(0));
    leak = 0;
    repeat (3) begin
      @(posedge clk); #1;
      leak += 32'({bus.cpu_ready, bus.mem_rd, bus.mem_wr, bus.cm_write_en} != 4'b0);
    end
    chk("held_in_reset", 256'(leak), 256'(0));
    rst_n = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    @(posedge clk); #1;

    do_req(1'b0, 28'h000_8010, 32'h0, 0, 1);
    do_req(1'b0, 28'h000_0011, 32'h0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      a = {14'($urandom_range(2, 0)), 11'($urandom_range(2, 0) * 3 + 2), 3'($urandom_range(7, 0))};
      do_req(($urandom_range(2, 0) == 0), a, $urandom(),
             $urandom_range(3, 0), $urandom_range(3, 0));
    end

`ifdef CC_STATS_EN
    chk("hit_cnt", 256'(hit_cnt), 256'(exp_hits));
    chk("miss_cnt", 256'(miss_cnt), 256'(exp_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
